// File: rtl/gate_checker.sv
// -----------------------------------------------------------------------------
// gate_checker
//
// Exhaustively exercises a 2-input gate under test. It walks the four input
// vectors v = {a,b} = 00, 01, 10, 11. Each vector is held for SETTLE cycles
// and then sampled for one cycle. The response c is compared with TRUTH[v].
// At the end of a run the block reports the result, which is held until the
// next accepted start.
//
// Parameters
//   SETTLE   : cycles each vector is held before sampling (1..15)
//   TRUTH    : expected response; TRUTH[v] is the expected c for v = {a,b}
//
// Ports
//   clk      : in  - single clock, rising edge
//   rst      : in  - synchronous active-high reset
//   start    : in  - request a check run (only looked at while idle)
//   a, b     : out - stimulus to the gate under test (a = v[1], b = v[0])
//   c        : in  - response from the gate under test (already synchronous)
//   busy     : out - high from the first run cycle through the DONE cycle
//   done     : out - one-cycle pulse at run completion
//   pass     : out - 1 when all four vectors of the last run matched
//   fail_vec : out - first mismatching vector of the last run (0 if none)
//   fail_cnt : out - number of mismatching vectors of the last run (0..4)
// -----------------------------------------------------------------------------
module gate_checker #(
    parameter int          SETTLE = 2,
    parameter logic [3:0]  TRUTH  = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
    output logic [2:0] fail_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter value seen in the last SETTLE cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_v;
    logic [3:0] r_cnt;
    logic [2:0] r_fail_cnt;
    logic [1:0] r_fail_vec;
    logic       r_pass;

    logic       w_mis;
    logic [2:0] w_fail_cnt_nx;

    assign w_mis         = (c != TRUTH[r_v]);
    assign w_fail_cnt_nx = r_fail_cnt + {2'b00, w_mis};

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        a      = 1'b0;
        b      = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                a    = r_v[1];
                b    = r_v[0];
                busy = 1'b1;
                if (r_cnt == SETTLE_LAST) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                a    = r_v[1];
                b    = r_v[0];
                busy = 1'b1;
                w_next = (r_v == 2'd3) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and run datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_v        <= 2'd0;
            r_cnt      <= 4'd0;
            r_fail_cnt <= 3'd0;
            r_fail_vec <= 2'd0;
            r_pass     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_v        <= 2'd0;
                        r_cnt      <= 4'd0;
                        r_fail_cnt <= 3'd0;
                        r_fail_vec <= 2'd0;
                        r_pass     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    if (w_mis) begin
                        r_fail_cnt <= w_fail_cnt_nx;
                        // Only the first mismatch of the run is recorded.
                        if (r_fail_cnt == 3'd0) begin
                            r_fail_vec <= r_v;
                        end
                    end
                    if (r_v != 2'd3) begin
                        r_v   <= r_v + 2'd1;
                        r_cnt <= 4'd0;
                    end else begin
                        // Settled on the edge into DONE so the verdict is
                        // already valid while done is high.
                        r_pass <= (w_fail_cnt_nx == 3'd0);
                    end
                end
                S_DONE: begin
                    r_v <= 2'd0;
                end
                default: begin
                    r_v <= 2'd0;
                end
            endcase
        end
    end

    assign pass     = r_pass;
    assign fail_vec = r_fail_vec;
    assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_gate_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_checker
//
// Drives gate_checker with a behavioural gate model (a 4-entry table g, c =
// g[{a,b}]) chosen per run, either directed or random. A per-cycle monitor
// derives the expected a/b/busy/done/result outputs from the run start cycle
// with plain arithmetic. A scoreboard queue holds the expected completion of
// every issued run and is popped whenever done is seen. A second instance with
// SETTLE=1 and an XOR truth table covers the short-settle timing.
// -----------------------------------------------------------------------------
module tb_gate_checker;

    localparam int         S      = 2;
    localparam logic [3:0] T      = 4'b1000;
    localparam int         RUNLEN = 4 * (S + 1);

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, a, b, c, busy, done, pass;
    logic [1:0] fail_vec;
    logic [2:0] fail_cnt;
    logic [3:0] g;
    assign c = g[{a, b}];

    logic       start1, a1, b1, c1, busy1, done1, pass1;
    logic [1:0] fail_vec1;
    logic [2:0] fail_cnt1;
    logic [3:0] g1;
    assign c1 = g1[{a1, b1}];

    gate_checker #(.SETTLE(S), .TRUTH(T)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass),
        .fail_vec(fail_vec), .fail_cnt(fail_cnt)
    );

    gate_checker #(.SETTLE(1), .TRUTH(4'b0110)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fail_vec1), .fail_cnt(fail_cnt1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A record starts at the edge where a run start (or a reset) is sampled.
    typedef struct {
        int         e;
        bit         is_rst;
        logic [3:0] g;
    } rec_t;
    rec_t recs[$];

    typedef struct {
        int         dcyc;
        logic [2:0] cnt;
        logic [1:0] fv;
        logic       p;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of the first n sampled vectors given mismatch mask m.
    function automatic void model(input logic [3:0] m, input int n,
                                  output logic [2:0] cnt, output logic [1:0] fv);
        cnt = 3'd0;
        fv  = 2'd0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m[i]) begin
                cnt = cnt + 3'd1;
                fv  = 2'(i);
            end
        end
    endfunction

    // Per-cycle monitor and done-driven scoreboard.
    always @(negedge clk) begin : mon
        int         idx;
        int         k;
        int         v;
        logic [3:0] m;
        logic       ea, eb, ebusy, edone, ep;
        logic [2:0] ecnt;
        logic [1:0] efv;
        exp_t       x;
        idx = -1;
        for (int i = 0; i < recs.size(); i++) begin
            if (recs[i].e <= cyc) idx = i;
        end
        if (idx >= 0) begin
            ea = 0; eb = 0; ebusy = 0; edone = 0; ep = 0; ecnt = 0; efv = 0;
            if (!recs[idx].is_rst) begin
                k = cyc - recs[idx].e + 1;
                m = recs[idx].g ^ T;
                if (k <= RUNLEN) begin
                    v     = (k - 1) / (S + 1);
                    ea    = v[1];
                    eb    = v[0];
                    ebusy = 1'b1;
                    model(m, v, ecnt, efv);
                end else begin
                    model(m, 4, ecnt, efv);
                    ep = (m == 4'b0000);
                    if (k == RUNLEN + 1) begin
                        ebusy = 1'b1;
                        edone = 1'b1;
                    end
                end
            end
            chk("a", a, ea);
            chk("b", b, eb);
            chk("busy", busy, ebusy);
            chk("done", done, edone);
            chk("pass", pass, ep);
            chk("fail_cnt", fail_cnt, ecnt);
            chk("fail_vec", fail_vec, efv);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("sb_done_cycle", cyc, x.dcyc);
                chk("sb_pass", pass, x.p);
                chk("sb_fail_cnt", fail_cnt, x.cnt);
                chk("sb_fail_vec", fail_vec, x.fv);
            end
        end
    end

    // Register a run accepted at edge e with gate table gt.
    task automatic expect_run(input int e, input logic [3:0] gt);
        rec_t r;
        exp_t x;
        r.e = e; r.is_rst = 1'b0; r.g = gt;
        recs.push_back(r);
        x.dcyc = e + RUNLEN;
        model(gt ^ T, 4, x.cnt, x.fv);
        x.p = ((gt ^ T) == 4'b0000);
        sb.push_back(x);
    endtask

    // Called at a negedge: one-cycle start pulse; returns at run cycle 1.
    task automatic issue(input logic [3:0] gt);
        g     = gt;
        start = 1'b1;
        expect_run(cyc + 1, gt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_once(input logic [3:0] gt);
        @(negedge clk);
        issue(gt);
        repeat (RUNLEN + 3) @(negedge clk);
    endtask

    // Called at a negedge: reset sampled on the next edge.
    task automatic do_reset();
        rec_t r;
        int   rr;
        rst = 1'b1;
        rr  = cyc + 1;
        r.e = rr; r.is_rst = 1'b1; r.g = 4'b0000;
        recs.push_back(r);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].dcyc >= rr) sb.delete(i);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rec_t r0;
        int   c0;
        int   e;
        int   n;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        g      = 4'b0000;
        g1     = 4'b0110;
        r0.e = 1; r0.is_rst = 1'b1; r0.g = 4'b0000;
        recs.push_back(r0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed gate models: AND, stuck-at-0, OR, XOR.
        run_once(4'b1000);
        run_once(4'b0000);
        run_once(4'b1110);
        run_once(4'b0110);

        // Random gate models.
        for (int i = 0; i < 8; i++) begin
            run_once(4'($urandom_range(0, 15)));
        end

        // start held high for 40 edges: back-to-back runs.
        @(negedge clk);
        g     = 4'b1000;
        start = 1'b1;
        c0    = cyc;
        e     = c0 + 1;
        while (e <= c0 + 40) begin
            expect_run(e, 4'b1000);
            e += RUNLEN + 2;
        end
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (RUNLEN + 4) @(negedge clk);

        // Start pulses while busy are ignored.
        @(negedge clk);
        issue(4'b1110);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RUNLEN) @(negedge clk);

        // Reset during the first SETTLE cycle of vector 2, then a clean run.
        @(negedge clk);
        issue(4'b0000);
        repeat (2 * (S + 1)) @(negedge clk);
        do_reset();
        repeat (RUNLEN + 3) @(negedge clk);
        run_once(4'b1000);

        // Short-settle instance with XOR truth: done in cycle 9.
        for (int t = 0; t < 2; t++) begin
            g1 = (t == 0) ? 4'b0110 : 4'b1000;
            @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            n = 1;
            while (done1 !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("dut1_done_cycle", n, 9);
            chk("dut1_pass", pass1, (t == 0) ? 1 : 0);
            chk("dut1_fail_cnt", fail_cnt1, (t == 0) ? 0 : 3);
            chk("dut1_fail_vec", fail_vec1, (t == 0) ? 0 : 1);
            repeat (3) @(negedge clk);
            chk("dut1_busy_idle", busy1, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter: SETTLE, default 2, cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 Parameter: TRUTH, default 4'b1000 (2-input AND), expected output; TRUTH[v] is the expected c for vector v = {a,b}.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request one check run; sampled only in IDLE.
REQ-006 Port: a  output  1  stimulus to gate under test; equals v[1].
REQ-007 Port: b  output  1  stimulus to gate under test; equals v[0].
REQ-008 Port: c  input  1  response from gate under test.
REQ-009 Port: busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-010 Port: done  output  1  single-cycle pulse marking run completion.
REQ-011 Port: pass  output  1  result of last completed run; 1 = all four vectors matched.
REQ-012 Port: fail_vec  output  2  first mismatching vector of last run; 0 if none.
REQ-013 Port: fail_cnt  output  3  number of mismatching vectors of last run, 0..4.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: a=b=0, busy=0; start=1 at an edge SHALL set v=0, fail_cnt=0, fail_vec=0, pass=0, settle counter=0, and go to SETTLE.
REQ-016 SETTLE: a,b SHALL drive v; the counter SHALL increment each cycle; after SETTLE cycles in SETTLE the FSM SHALL go to SAMPLE.
REQ-017 SAMPLE (one cycle, a,b still = v): if c != TRUTH[v], fail_cnt SHALL increment, and fail_vec SHALL load v only if fail_cnt was 0.
REQ-018 SAMPLE with v<3 SHALL increment v, clear the counter, and return to SETTLE; with v=3 it SHALL go to DONE.
REQ-019 DONE (one cycle): done=1, busy=1, a=b=0, pass SHALL register (final fail_cnt==0); next state IDLE unconditionally.
REQ-020 Each vector SHALL occupy exactly SETTLE+1 cycles; done SHALL be high in cycle 4*(SETTLE+1)+1 counted from the first cycle after the start-sampling edge (cycle 13 for SETTLE=2).
REQ-021 start while not in IDLE SHALL be ignored; start held high SHALL begin a new run on the IDLE cycle following DONE.
REQ-022 The fail_cnt update, fail_vec capture, and v increment in SAMPLE SHALL all occur on the same edge.
REQ-023 pass, fail_vec, and fail_cnt SHALL hold their values from DONE until the next accepted start.
REQ-024 c SHALL be treated as a synchronous input; the block SHALL NOT add an input synchronizer.

Reset
REQ-025 rst=1 at any edge SHALL force the state to IDLE with a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, fail_cnt=0, v=0, and counter=0.
REQ-026 rst SHALL take priority over start and over every state transition; a run aborted by reset SHALL produce no done pulse.

Verification
REQ-027 AND model on c, defaults, one-cycle start pulse -> {a,b} = 00,01,10,11, each held 3 cycles; done in cycle 13; pass=1, fail_cnt=0, fail_vec=0.
REQ-028 c stuck at 0, defaults -> only vector 3 mismatches; pass=0, fail_cnt=1, fail_vec=3.
REQ-029 OR model on c, TRUTH=4'b1000 -> vectors 1 and 2 mismatch; fail_cnt=2, fail_vec=1, pass=0.
REQ-030 XOR model with TRUTH=4'b0110, SETTLE=1 -> done in cycle 9, pass=1.
REQ-031 start held high for 40 cycles, defaults, AND model -> done pulses 14 cycles apart; results are cleared and recomputed each run; busy is low for exactly one cycle between runs.
REQ-032 rst pulsed during SETTLE of vector 2 -> next cycle all outputs are 0 and no done occurs; a fresh start then completes normally with pass=1.
